regfile_write_scheduler: RTL and testbench

- Schedules the single register-file write port between two sources: the in-order pipeline writeback (primary) and the long-latency unit return path for loads and divides (secondary).
- Buffers secondary results in a small FIFO and drives the register file write port (EnW/AddrW/DataW).
- Keeps a busy scoreboard of registers with outstanding long-latency results and raises read/issue stalls to the pipeline.

---
 rtl/regfile_write_scheduler_if.sv | 38 +++
 rtl/regfile_write_scheduler.sv | 109 ++++++++++
 tb/tb_regfile_write_scheduler.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_scheduler_if.sv
// Register-file write scheduler bus: pipeline writeback, long-latency return,
// scoreboard checks and the resulting register-file write port.
interface regfile_write_scheduler_if #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 5
);
  logic              PriEn;
  logic [W_ADDR-1:0] PriAddr;
  logic [W_DATA-1:0] PriData;
  logic              SecValid;
  logic              SecReady;
  logic [W_ADDR-1:0] SecAddr;
  logic [W_DATA-1:0] SecData;
  logic              IssueEn;
  logic [W_ADDR-1:0] IssueAddr;
  logic              IssueConflict;
  logic              ChkEnX;
  logic              ChkEnY;
  logic [W_ADDR-1:0] ChkAddrX;
  logic [W_ADDR-1:0] ChkAddrY;
  logic              RdStall;
  logic              PipeHold;
  logic              RfEnW;
  logic [W_ADDR-1:0] RfAddrW;
  logic [W_DATA-1:0] RfDataW;

  modport master (
    output PriEn, PriAddr, PriData, SecValid, SecAddr, SecData,
           IssueEn, IssueAddr, ChkEnX, ChkEnY, ChkAddrX, ChkAddrY,
    input  SecReady, IssueConflict, RdStall, PipeHold, RfEnW, RfAddrW, RfDataW
  );

  modport slave (
    input  PriEn, PriAddr, PriData, SecValid, SecAddr, SecData,
           IssueEn, IssueAddr, ChkEnX, ChkEnY, ChkAddrX, ChkAddrY,
    output SecReady, IssueConflict, RdStall, PipeHold, RfEnW, RfAddrW, RfDataW
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Arbitrates the single register-file write port between pipeline writeback and
// buffered long-latency returns, and tracks registers with results still in flight.
module regfile_write_scheduler #(
  parameter int W_DATA       = 32,
  parameter int W_ADDR       = 5,
  parameter int IDX_ZR       = 31,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                     Clock,
  input logic                     Reset,
  regfile_write_scheduler_if.slave Bus
);
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam int N_REG    = 1 << W_ADDR;
  localparam logic [W_ADDR-1:0]   ADDR_ZR     = W_ADDR'(IDX_ZR);
  localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(FIFO_DEPTH);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);

  logic [W_ADDR-1:0]   fifoAddr [FIFO_DEPTH];
  logic [W_DATA-1:0]   fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]    rdPtr, wrPtr;
  logic [CNT_W-1:0]    count;
  logic [N_REG-1:0]    busy, busyNext;
  logic [STARVE_W-1:0] starveCnt, starveCntNext;
  logic                pipeHold, pipeHoldNext;

  logic              fifoEmpty, fifoFull;
  logic              secReady, push, pop;
  logic              issueConflict, issueOk;
  logic [W_ADDR-1:0] headAddr;
  logic [W_DATA-1:0] headData;

  always_comb begin
    fifoEmpty = (count == '0);
    fifoFull  = (count == CNT_FULL);
    headAddr  = fifoAddr[rdPtr];
    headData  = fifoData[rdPtr];

    // Readiness looks only at registered occupancy; a pop this cycle does not open a slot.
    secReady = !Reset && !fifoFull;
    push     = Bus.SecValid && secReady && (Bus.SecAddr != ADDR_ZR);
    pop      = !Reset && !Bus.PriEn && !fifoEmpty;

    Bus.SecReady = secReady;
    Bus.RfEnW    = 1'b0;
    Bus.RfAddrW  = '0;
    Bus.RfDataW  = '0;
    if (!Reset) begin
      if (Bus.PriEn) begin
        Bus.RfEnW   = 1'b1;
        Bus.RfAddrW = Bus.PriAddr;
        Bus.RfDataW = Bus.PriData;
      end else if (!fifoEmpty) begin
        Bus.RfEnW   = 1'b1;
        Bus.RfAddrW = headAddr;
        Bus.RfDataW = headData;
      end
    end

    issueConflict     = !Reset && Bus.IssueEn && busy[Bus.IssueAddr];
    issueOk           = Bus.IssueEn && !issueConflict && (Bus.IssueAddr != ADDR_ZR);
    Bus.IssueConflict = issueConflict;
    Bus.RdStall       = !Reset && ((Bus.ChkEnX && busy[Bus.ChkAddrX]) ||
                                   (Bus.ChkEnY && busy[Bus.ChkAddrY]));
    Bus.PipeHold      = pipeHold;

    // Clear before set so a new issue to the returning register stays busy.
    busyNext = busy;
    if (pop)     busyNext[headAddr]      = 1'b0;
    if (issueOk) busyNext[Bus.IssueAddr] = 1'b1;
    busyNext[IDX_ZR] = 1'b0;

    starveCntNext = '0;
    pipeHoldNext  = 1'b0;
    if (Bus.PriEn && !fifoEmpty) begin
      if (starveCnt == STARVE_LAST) pipeHoldNext  = 1'b1;
      else                          starveCntNext = starveCnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      busy      <= '0;
      starveCnt <= '0;
      pipeHold  <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (!push && pop) count <= count - CNT_W'(1);
      busy      <= busyNext;
      starveCnt <= starveCntNext;
      pipeHold  <= pipeHoldNext;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      fifoAddr[wrPtr] <= Bus.SecAddr;
      fifoData[wrPtr] <= Bus.SecData;
    end
  end
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_regfile_write_scheduler;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct { logic [4:0] addr; logic [31:0] data; } ent_t;

  logic Clock;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  regfile_write_scheduler_if #(.W_DATA(32), .W_ADDR(5)) bus ();

  regfile_write_scheduler #(
    .W_DATA(32), .W_ADDR(5), .IDX_ZR(31), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Bus  (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge Clock);
    #1;
  endtask

  task automatic idle;
    bus.PriEn = 0; bus.PriAddr = '0; bus.PriData = '0;
    bus.SecValid = 0; bus.SecAddr = '0; bus.SecData = '0;
    bus.IssueEn = 0; bus.IssueAddr = '0;
    bus.ChkEnX = 0; bus.ChkEnY = 0; bus.ChkAddrX = '0; bus.ChkAddrY = '0;
  endtask

  task automatic test_reset;
    Reset = 1; idle;
    bus.PriEn = 1; bus.PriAddr = 3; bus.PriData = 32'h55;
    bus.SecValid = 1; bus.SecAddr = 4; bus.IssueEn = 1; bus.IssueAddr = 6;
    bus.ChkEnX = 1; bus.ChkAddrX = 6;
    #1;
    tests++; if (bus.RfEnW !== 1'b0) begin fails++; $display("FAIL reset_rfenw got %b want 0", bus.RfEnW); end
    tests++; if (bus.SecReady !== 1'b0) begin fails++; $display("FAIL reset_secready got %b want 0", bus.SecReady); end
    tests++; if ({bus.IssueConflict, bus.RdStall} !== 2'b00) begin fails++; $display("FAIL reset_stalls got %b want 00", {bus.IssueConflict, bus.RdStall}); end
    step;
    Reset = 0; idle;
    bus.PriEn = 1; bus.PriAddr = 3; bus.PriData = 32'h55;
    #1;
    tests++; if (bus.RfEnW !== 1'b1 || bus.RfAddrW !== 5'd3) begin fails++; $display("FAIL post_reset_pri got en=%b addr=%0d want en=1 addr=3", bus.RfEnW, bus.RfAddrW); end
    tests++; if (bus.PipeHold !== 1'b0 || bus.SecReady !== 1'b1) begin fails++; $display("FAIL post_reset_state got hold=%b rdy=%b want 0 1", bus.PipeHold, bus.SecReady); end
    step; idle; #1;
    tests++; if (bus.RfEnW !== 1'b0) begin fails++; $display("FAIL post_reset_empty got %b want 0", bus.RfEnW); end
  endtask

  task automatic test_issue_return;
    idle; bus.IssueEn = 1; bus.IssueAddr = 7; #1;
    tests++; if (bus.IssueConflict !== 1'b0) begin fails++; $display("FAIL issue7_conflict got %b want 0", bus.IssueConflict); end
    step; idle;
    bus.ChkEnX = 1; bus.ChkAddrX = 7; #1;
    tests++; if (bus.RdStall !== 1'b1) begin fails++; $display("FAIL busy7_rdstall got %b want 1", bus.RdStall); end
    bus.SecValid = 1; bus.SecAddr = 7; bus.SecData = 32'hDEADBEEF; #1;
    tests++; if (bus.SecReady !== 1'b1 || bus.RfEnW !== 1'b0) begin fails++; $display("FAIL ret7_accept got rdy=%b en=%b want 1 0", bus.SecReady, bus.RfEnW); end
    step; bus.SecValid = 0; #1;
    tests++; if (bus.RfEnW !== 1'b1 || bus.RfAddrW !== 5'd7 || bus.RfDataW !== 32'hDEADBEEF) begin fails++; $display("FAIL ret7_write got en=%b addr=%0d data=%h want 1 7 deadbeef", bus.RfEnW, bus.RfAddrW, bus.RfDataW); end
    tests++; if (bus.RdStall !== 1'b1) begin fails++; $display("FAIL ret7_stall_before_pop got %b want 1", bus.RdStall); end
    step; #1;
    tests++; if (bus.RdStall !== 1'b0 || bus.RfEnW !== 1'b0) begin fails++; $display("FAIL ret7_cleared got stall=%b en=%b want 0 0", bus.RdStall, bus.RfEnW); end
    idle;
  endtask

  task automatic test_collision;
    idle;
    bus.PriEn = 1; bus.PriAddr = 4; bus.PriData = 32'h44;
    bus.SecValid = 1; bus.SecAddr = 5; bus.SecData = 32'h22;
    step;
    bus.PriAddr = 2; bus.PriData = 32'h11; bus.SecAddr = 6; bus.SecData = 32'h33; #1;
    tests++; if (bus.RfAddrW !== 5'd2 || bus.RfDataW !== 32'h11 || bus.SecReady !== 1'b1) begin fails++; $display("FAIL coll_pri got addr=%0d data=%h rdy=%b want 2 11 1", bus.RfAddrW, bus.RfDataW, bus.SecReady); end
    step; idle; #1;
    tests++; if (bus.RfEnW !== 1'b1 || bus.RfAddrW !== 5'd5 || bus.RfDataW !== 32'h22 || bus.SecReady !== 1'b0) begin fails++; $display("FAIL coll_head1 got en=%b addr=%0d data=%h rdy=%b want 1 5 22 0", bus.RfEnW, bus.RfAddrW, bus.RfDataW, bus.SecReady); end
    step; #1;
    tests++; if (bus.RfEnW !== 1'b1 || bus.RfAddrW !== 5'd6 || bus.RfDataW !== 32'h33) begin fails++; $display("FAIL coll_head2 got en=%b addr=%0d data=%h want 1 6 33", bus.RfEnW, bus.RfAddrW, bus.RfDataW); end
    step; #1;
    tests++; if (bus.RfEnW !== 1'b0) begin fails++; $display("FAIL coll_drained got %b want 0", bus.RfEnW); end
  endtask

  task automatic test_full_fifo;
    idle;
    bus.PriEn = 1; bus.PriAddr = 1; bus.PriData = 32'h1;
    bus.SecValid = 1; bus.SecAddr = 10; bus.SecData = 32'hA0; #1;
    tests++; if (bus.SecReady !== 1'b1) begin fails++; $display("FAIL full_rdy0 got %b want 1", bus.SecReady); end
    step; bus.SecAddr = 11; bus.SecData = 32'hB0; step;
    bus.SecAddr = 12; bus.SecData = 32'hC0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++; if (bus.SecReady !== 1'b0 || bus.RfAddrW !== 5'd1) begin fails++; $display("FAIL full_held%0d got rdy=%b addr=%0d want 0 1", k, bus.SecReady, bus.RfAddrW); end
      step;
    end
    bus.PriEn = 0; #1;
    tests++; if (bus.RfAddrW !== 5'd10 || bus.RfDataW !== 32'hA0 || bus.SecReady !== 1'b0 || bus.PipeHold !== 1'b0) begin fails++; $display("FAIL full_pop1 got addr=%0d data=%h rdy=%b hold=%b want 10 a0 0 0", bus.RfAddrW, bus.RfDataW, bus.SecReady, bus.PipeHold); end
    step; #1;
    tests++; if (bus.SecReady !== 1'b1 || bus.RfAddrW !== 5'd11 || bus.RfDataW !== 32'hB0) begin fails++; $display("FAIL full_pop2 got rdy=%b addr=%0d data=%h want 1 11 b0", bus.SecReady, bus.RfAddrW, bus.RfDataW); end
    step; bus.SecValid = 0; #1;
    tests++; if (bus.RfEnW !== 1'b1 || bus.RfAddrW !== 5'd12 || bus.RfDataW !== 32'hC0) begin fails++; $display("FAIL full_pop3 got en=%b addr=%0d data=%h want 1 12 c0", bus.RfEnW, bus.RfAddrW, bus.RfDataW); end
    step; #1;
    tests++; if (bus.RfEnW !== 1'b0) begin fails++; $display("FAIL full_nodup got %b want 0", bus.RfEnW); end
  endtask

  task automatic test_starvation;
    for (int pass = 0; pass < 2; pass++) begin
      idle;
      bus.PriEn = 1; bus.PriAddr = 2; bus.PriData = 32'h2;
      bus.SecValid = 1; bus.SecAddr = 13; bus.SecData = 32'hD0 + 32'(pass);
      step; bus.SecValid = 0;
      for (int k = 1; k <= LIMIT; k++) begin
        #1;
        tests++; if (bus.PipeHold !== 1'b0 || bus.RfAddrW !== 5'd2) begin fails++; $display("FAIL starve_p%0d_c%0d got hold=%b addr=%0d want 0 2", pass, k, bus.PipeHold, bus.RfAddrW); end
        step;
      end
      // second pass keeps PriEn during the hold: primary still wins, no extension
      bus.PriEn = (pass == 1); #1;
      tests++; if (bus.PipeHold !== 1'b1 || bus.RfAddrW !== (pass == 1 ? 5'd2 : 5'd13)) begin fails++; $display("FAIL starve_hold_p%0d got hold=%b addr=%0d", pass, bus.PipeHold, bus.RfAddrW); end
      step; #1;
      tests++; if (bus.PipeHold !== 1'b0) begin fails++; $display("FAIL starve_after_p%0d got %b want 0", pass, bus.PipeHold); end
      bus.PriEn = 0; #1;
      if (pass == 1) begin
        tests++; if (bus.RfAddrW !== 5'd13 || bus.RfDataW !== 32'hD1) begin fails++; $display("FAIL starve_late_pop got addr=%0d data=%h want 13 d1", bus.RfAddrW, bus.RfDataW); end
        step; #1;
      end
      tests++; if (bus.RfEnW !== 1'b0) begin fails++; $display("FAIL starve_empty_p%0d got %b want 0", pass, bus.RfEnW); end
    end
    idle;
  endtask

  task automatic test_zero_conflict;
    idle; bus.SecValid = 1; bus.SecAddr = 31; bus.SecData = 32'hFF; #1;
    tests++; if (bus.SecReady !== 1'b1) begin fails++; $display("FAIL zr_accept got %b want 1", bus.SecReady); end
    step; idle; #1;
    tests++; if (bus.RfEnW !== 1'b0 || bus.SecReady !== 1'b1) begin fails++; $display("FAIL zr_discard got en=%b rdy=%b want 0 1", bus.RfEnW, bus.SecReady); end
    bus.IssueEn = 1; bus.IssueAddr = 31; step; idle;
    bus.ChkEnX = 1; bus.ChkAddrX = 31; #1;
    tests++; if (bus.RdStall !== 1'b0) begin fails++; $display("FAIL zr_busy got %b want 0", bus.RdStall); end
    idle; bus.IssueEn = 1; bus.IssueAddr = 9; step; #1;
    tests++; if (bus.IssueConflict !== 1'b1) begin fails++; $display("FAIL conflict9 got %b want 1", bus.IssueConflict); end
    step; idle; bus.ChkEnY = 1; bus.ChkAddrY = 9; #1;
    tests++; if (bus.RdStall !== 1'b1) begin fails++; $display("FAIL busy9_kept got %b want 1", bus.RdStall); end
    idle; bus.SecValid = 1; bus.SecAddr = 20; bus.SecData = 32'h20; step;
    idle; bus.IssueEn = 1; bus.IssueAddr = 20; #1;
    tests++; if (bus.RfAddrW !== 5'd20 || bus.IssueConflict !== 1'b0) begin fails++; $display("FAIL setwin_cycle got addr=%0d conf=%b want 20 0", bus.RfAddrW, bus.IssueConflict); end
    step; idle; bus.ChkEnY = 1; bus.ChkAddrY = 20; #1;
    tests++; if (bus.RdStall !== 1'b1) begin fails++; $display("FAIL setwin_busy got %b want 1", bus.RdStall); end
    idle;
  endtask

  task automatic test_random;
    ent_t        mq[$];
    bit   [31:0] mbusy;
    int          streak;
    bit          mhold;
    bit          nonempty, accept, conflict, expEn, expStall;
    logic [4:0]  expAddr;
    logic [31:0] expData;
    Reset = 1; idle; step; Reset = 0;
    mq.delete(); mbusy = '0; streak = 0; mhold = 0;
    for (int i = 0; i < 600; i++) begin
      Reset = (i == 300);
      bus.PriEn    = mhold ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 1) == 1);
      bus.PriAddr  = 5'($urandom_range(0, 31)); bus.PriData = $urandom;
      bus.SecValid = $urandom_range(0, 1) == 1;
      bus.SecAddr  = 5'($urandom_range(0, 31)); bus.SecData = $urandom;
      bus.IssueEn  = $urandom_range(0, 9) < 3;
      bus.IssueAddr = 5'($urandom_range(0, 31));
      bus.ChkEnX = $urandom_range(0, 1) == 1; bus.ChkAddrX = 5'($urandom_range(0, 31));
      bus.ChkEnY = $urandom_range(0, 1) == 1; bus.ChkAddrY = 5'($urandom_range(0, 31));
      nonempty = mq.size() != 0;
      accept   = !Reset && bus.SecValid && mq.size() < DEPTH;
      conflict = !Reset && bus.IssueEn && mbusy[bus.IssueAddr];
      expStall = !Reset && ((bus.ChkEnX && mbusy[bus.ChkAddrX]) || (bus.ChkEnY && mbusy[bus.ChkAddrY]));
      expEn = 0; expAddr = '0; expData = '0;
      if (!Reset && bus.PriEn) begin expEn = 1; expAddr = bus.PriAddr; expData = bus.PriData; end
      else if (!Reset && nonempty) begin expEn = 1; expAddr = mq[0].addr; expData = mq[0].data; end
      #1;
      tests++;
      if ({bus.RfEnW, bus.RfAddrW, bus.RfDataW} !== {expEn, expAddr, expData}) begin
        fails++; $display("FAIL rnd_write cyc %0d got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", i, bus.RfEnW, bus.RfAddrW, bus.RfDataW, expEn, expAddr, expData);
      end
      tests++;
      if ({bus.SecReady, bus.IssueConflict, bus.RdStall} !== {!Reset && mq.size() < DEPTH, conflict, expStall}) begin
        fails++; $display("FAIL rnd_flags cyc %0d got rdy/conf/stall=%b%b%b want %b%b%b", i, bus.SecReady, bus.IssueConflict, bus.RdStall, !Reset && mq.size() < DEPTH, conflict, expStall);
      end
      if (!Reset) begin
        tests++; if (bus.PipeHold !== mhold) begin fails++; $display("FAIL rnd_hold cyc %0d got %b want %b", i, bus.PipeHold, mhold); end
      end
      step;
      if (Reset) begin
        mq.delete(); mbusy = '0; streak = 0; mhold = 0;
      end else begin
        if (!bus.PriEn && nonempty) begin mbusy[mq[0].addr] = 0; void'(mq.pop_front()); end
        if (accept && bus.SecAddr != 5'd31) mq.push_back('{bus.SecAddr, bus.SecData});
        if (bus.IssueEn && !conflict && bus.IssueAddr != 5'd31) mbusy[bus.IssueAddr] = 1;
        streak = (bus.PriEn && nonempty) ? streak + 1 : 0;
        mhold = (streak == LIMIT);
        if (mhold) streak = 0;
      end
    end
    Reset = 0; idle;
  endtask

  initial begin
    test_reset;
    test_issue_return;
    test_collision;
    test_full_fifo;
    test_starvation;
    test_zero_conflict;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
